byte_mix_columns_unit: RTL
==========================

BYTE_MIX_COLUMNS_UNIT -- requirements
Module: byte_mix_columns_unit

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset; asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have ports: in_valid  input  1  in_byte is presented this cycle and is accepted.
REQ-004 SHALL have ports: in_byte  input  8  byte-serial state from the ShiftRows byte permutation stage, column-major order a0,a1,a2,a3 per column.
REQ-005 SHALL have ports: bypass  input  1  final-round flag; sampled only with byte 0 of each column.
REQ-006 SHALL have ports: flush  input  1  synchronous abort of all in-flight data.
REQ-007 SHALL have ports: out_valid  output  1  out_byte is valid this cycle.
REQ-008 SHALL have ports: out_byte  output  8  mixed byte stream, registered.
REQ-009 SHALL have ports: out_last  output  1  high with the 16th output byte of a 128-bit block.

Function
REQ-010 SHALL count accepted bytes with a 2-bit input index (0..3, wraps 3->0); the index advances only when in_valid=1, so in_valid gaps stall collection without loss.
REQ-011 SHALL hold a0..a2 in a collect buffer; on acceptance of a3 (cycle T), the complete column (a3 taken directly from in_byte) SHALL be transferred into an output buffer in the same edge.
REQ-012 SHALL compute, on transfer: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, in GF(2^8); 2x = (x<<1) ^ (x[7] ? 8'h1B : 8'h00), 3x = 2x ^ x; all arithmetic 8-bit.
REQ-013 SHALL, when the bypass value sampled with a0 was 1, set b_i = a_i for that column.
REQ-014 SHALL drive b0,b1,b2,b3 on out_byte in cycles T+1..T+4 with out_valid=1 in exactly those four consecutive cycles, regardless of in_valid during that window (latency: a3 accepted -> b0 visible one cycle later).
REQ-015 SHALL use an output FSM with states OUT_IDLE (out_valid=0) and OUT_SHIFT (2-bit output index 0..3); OUT_IDLE->OUT_SHIFT on column transfer; OUT_SHIFT->OUT_IDLE after index 3 unless a new transfer occurs in the same cycle, in which case it stays in OUT_SHIFT with index 0 and the new column.
REQ-016 SHALL accept the next column's bytes while the previous column shifts out (full throughput, 1 byte/cycle sustained, no back-pressure); since a column needs at least 4 cycles to collect, buffer overrun cannot occur.
REQ-017 SHALL drive out_byte=8'h00 whenever out_valid=0.
REQ-018 SHALL count emitted columns with a 2-bit column counter; out_last=1 only with b3 of column 3, then the counter wraps to 0.
REQ-019 SHALL on flush=1: clear input index, output index, column counter, FSM to OUT_IDLE, out_valid/out_last to 0 at the next edge; an in_valid byte presented with flush is discarded (flush wins).
REQ-020 SHALL ignore bypass changes on bytes 1..3 of a column.

Reset
REQ-021 SHALL, while rst=0, force out_valid=0, out_last=0, out_byte=8'h00, all indices and counters to 0, buffers to 8'h00, FSM to OUT_IDLE.
REQ-022 SHALL, on reset asserted mid-column or mid-shift, discard all partial data; after release, the first accepted byte is treated as a0 of column 0.

Verification
REQ-023 SHALL cover: bytes db,13,53,45 on consecutive cycles, bypass=0 -> out 8e,4d,a1,bc with out_valid high 4 cycles starting cycle after 45.
REQ-024 SHALL cover: four back-to-back columns (f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6, db 13 53 45) -> 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6, 8e 4d a1 bc continuous, out_last only on final bc.
REQ-025 SHALL cover: column db,13,53,45 with bypass=1 on a0 (bypass=0 on others) -> out db,13,53,45.
REQ-026 SHALL cover: in_valid gaps of 1-3 cycles between bytes of f2,0a,22,5c -> same 9f,dc,58,9d output, b0 one cycle after 5c accepted.
REQ-027 SHALL cover: flush after 2 bytes, then db,13,53,45 -> only 8e,4d,a1,bc emitted; flush during output shift -> out_valid drops next cycle.
REQ-028 SHALL cover: rst pulsed low asynchronously (between clock edges) mid-shift -> out_valid=0 and out_byte=00 immediately, next column starts at a0.

Source files
------------

// File: rtl/byte_mix_columns_unit.sv
// Byte-serial AES MixColumns stage: collects four bytes per column, mixes them in GF(2^8)
// and shifts the mixed column out one byte per cycle while the next column is collected.
module byte_mix_columns_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       bypass,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last
);

  typedef enum logic [0:0] {
    OUT_IDLE  = 1'b0,
    OUT_SHIFT = 1'b1
  } out_state_e;

  // Element [0] holds byte 0 of the column.
  typedef logic [3:0][7:0] col_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  function automatic col_t mix_column(input col_t a);
    col_t b;
    b[0] = xtime(a[0]) ^ mul3(a[1]) ^ a[2]        ^ a[3];
    b[1] = a[0]        ^ xtime(a[1]) ^ mul3(a[2]) ^ a[3];
    b[2] = a[0]        ^ a[1]        ^ xtime(a[2]) ^ mul3(a[3]);
    b[3] = mul3(a[0])  ^ a[1]        ^ a[2]        ^ xtime(a[3]);
    mix_column = b;
  endfunction

  out_state_e state_q, state_d;
  logic [1:0] in_idx_q, in_idx_d;
  logic [7:0] a0_q, a0_d;
  logic [7:0] a1_q, a1_d;
  logic [7:0] a2_q, a2_d;
  logic       byp_q, byp_d;
  col_t       ob_q, ob_d;
  logic [1:0] out_idx_q, out_idx_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       out_last_q, out_last_d;

  logic       accept_s;
  logic       xfer_s;
  col_t       raw_col_s;
  col_t       new_col_s;

  assign accept_s  = in_valid & ~flush;
  assign xfer_s    = accept_s & (in_idx_q == 2'd3);
  assign raw_col_s = {in_byte, a2_q, a1_q, a0_q};
  assign new_col_s = byp_q ? raw_col_s : mix_column(raw_col_s);

  // Next-state logic for input collection, output shift FSM and registered outputs.
  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    byp_d       = byp_q;
    ob_d        = ob_q;
    out_idx_d   = out_idx_q;
    col_cnt_d   = col_cnt_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;

    if (flush) begin
      state_d     = OUT_IDLE;
      in_idx_d    = 2'd0;
      out_idx_d   = 2'd0;
      col_cnt_d   = 2'd0;
      out_valid_d = 1'b0;
      out_byte_d  = 8'h00;
      out_last_d  = 1'b0;
    end else begin
      if (accept_s) begin
        in_idx_d = in_idx_q + 2'd1;
        case (in_idx_q)
          2'd0: begin
            a0_d  = in_byte;
            byp_d = bypass;
          end
          2'd1:    a1_d = in_byte;
          2'd2:    a2_d = in_byte;
          default: a0_d = a0_q;
        endcase
      end else begin
        in_idx_d = in_idx_q;
      end

      case (state_q)
        OUT_IDLE: begin
          if (xfer_s) begin
            state_d     = OUT_SHIFT;
            ob_d        = new_col_s;
            out_idx_d   = 2'd0;
            out_valid_d = 1'b1;
            out_byte_d  = new_col_s[0];
            out_last_d  = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            out_byte_d  = 8'h00;
            out_last_d  = 1'b0;
          end
        end
        OUT_SHIFT: begin
          if (out_idx_q == 2'd3) begin
            // b3 has just been shown: the column is complete.
            col_cnt_d = col_cnt_q + 2'd1;
            if (xfer_s) begin
              ob_d        = new_col_s;
              out_idx_d   = 2'd0;
              out_valid_d = 1'b1;
              out_byte_d  = new_col_s[0];
              out_last_d  = 1'b0;
            end else begin
              state_d     = OUT_IDLE;
              out_idx_d   = 2'd0;
              out_valid_d = 1'b0;
              out_byte_d  = 8'h00;
              out_last_d  = 1'b0;
            end
          end else begin
            out_idx_d   = out_idx_q + 2'd1;
            out_valid_d = 1'b1;
            out_byte_d  = ob_q[out_idx_q + 2'd1];
            out_last_d  = (out_idx_q == 2'd2) && (col_cnt_q == 2'd3);
          end
        end
        default: begin
          state_d     = OUT_IDLE;
          out_idx_d   = 2'd0;
          out_valid_d = 1'b0;
          out_byte_d  = 8'h00;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OUT_IDLE;
      in_idx_q    <= 2'd0;
      a0_q        <= 8'h00;
      a1_q        <= 8'h00;
      a2_q        <= 8'h00;
      byp_q       <= 1'b0;
      ob_q        <= '0;
      out_idx_q   <= 2'd0;
      col_cnt_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      byp_q       <= byp_d;
      ob_q        <= ob_d;
      out_idx_q   <= out_idx_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;

endmodule
